// File: rtl/div_issue_ctrl_pkg.sv
// Shared definitions for the EX-stage divide issue controller: FSM encodings
// and the divider handshake levels.
package div_issue_ctrl_pkg;

    localparam int DIV_DW = 32;

    localparam logic DIV_START        = 1'b1;
    localparam logic DIV_STOP         = 1'b0;
    localparam logic DIV_RESULT_READY = 1'b1;

    localparam logic [DIV_DW-1:0] ZERO_WORD = '0;

    typedef enum logic [1:0] {
        CTRL_IDLE  = 2'd0,
        CTRL_BUSY  = 2'd1,
        CTRL_CLEAR = 2'd2
    } ctrl_state_e;

endpackage

// File: rtl/div_issue_ctrl_if.sv
// Controller <-> multicycle divider handshake bundle.
// Handshake: div_start_o is held high for the whole divide with stable operands;
// the result is valid only in the cycle div_ready_i is high, and dropping
// div_start_o for one cycle afterwards returns the divider to free.
interface div_issue_ctrl_if #(
    parameter int DW = div_issue_ctrl_pkg::DIV_DW
) ();
    logic            div_start_o;
    logic            div_annul_o;
    logic            div_signed_o;
    logic [DW-1:0]   div_op1_o;
    logic [DW-1:0]   div_op2_o;
    logic            div_ready_i;
    logic [2*DW-1:0] div_result_i;

    modport master (
        output div_start_o, div_annul_o, div_signed_o, div_op1_o, div_op2_o,
        input  div_ready_i, div_result_i
    );

    modport slave (
        input  div_start_o, div_annul_o, div_signed_o, div_op1_o, div_op2_o,
        output div_ready_i, div_result_i
    );
endinterface

// File: rtl/div_issue_ctrl.sv
// EX-stage divide issue controller: starts the divider, stalls until ready, then
// emits a one-cycle HI/LO write. Define DIV_ZERO_BYPASS_EN to retire x/0 in IDLE.
module div_issue_ctrl
    import div_issue_ctrl_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                div_op_i,
    input  logic                signed_i,
    input  logic [DW-1:0]       op1_i,
    input  logic [DW-1:0]       op2_i,
    input  logic                flush_i,
    div_issue_ctrl_if.master    div_if,
    output logic                stallreq_o,
    output logic                whilo_o,
    output logic [DW-1:0]       hi_o,
    output logic [DW-1:0]       lo_o,
    output logic                busy_o,
    output ctrl_state_e         state_dbg_o
);

    ctrl_state_e   state_q, state_d;
    logic          signed_q, signed_d;
    logic [DW-1:0] op1_q, op1_d;
    logic [DW-1:0] op2_q, op2_d;
    logic [DW-1:0] hi_q, hi_d;
    logic [DW-1:0] lo_q, lo_d;
    logic          whilo_q, whilo_d;

    logic          zero_bypass;
    logic          start;
    logic          stall;
    logic          sgn_out;
    logic [DW-1:0] op1_out;
    logic [DW-1:0] op2_out;

`ifdef DIV_ZERO_BYPASS_EN
    assign zero_bypass = (op2_i == '0);
`else
    assign zero_bypass = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        signed_d = signed_q;
        op1_d    = op1_q;
        op2_d    = op2_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        whilo_d  = 1'b0;
        start    = DIV_STOP;
        stall    = 1'b0;
        sgn_out  = signed_q;
        op1_out  = op1_q;
        op2_out  = op2_q;

        case (state_q)
            CTRL_IDLE: begin
                sgn_out = signed_i;
                op1_out = op1_i;
                op2_out = op2_i;
                if (div_op_i && !flush_i) begin
                    if (zero_bypass) begin
                        // Zero divisor retires without the divider: 0/0 next cycle.
                        whilo_d = 1'b1;
                        hi_d    = '0;
                        lo_d    = '0;
                    end else begin
                        start    = DIV_START;
                        stall    = 1'b1;
                        signed_d = signed_i;
                        op1_d    = op1_i;
                        op2_d    = op2_i;
                        state_d  = CTRL_BUSY;
                    end
                end
            end

            CTRL_BUSY: begin
                // Operands come from the latches: the divider re-reads the sign
                // bits at completion, so they must not follow the EX inputs.
                start = flush_i ? DIV_STOP : DIV_START;
                stall = (div_if.div_ready_i != DIV_RESULT_READY) && !flush_i;
                if (flush_i) begin
                    state_d = CTRL_CLEAR;
                end else if (div_if.div_ready_i == DIV_RESULT_READY) begin
                    hi_d    = div_if.div_result_i[2*DW-1:DW];
                    lo_d    = div_if.div_result_i[DW-1:0];
                    whilo_d = 1'b1;
                    state_d = CTRL_CLEAR;
                end
            end

            CTRL_CLEAR: begin
                // One cycle of start low releases the divider; a following DIV waits.
                start   = DIV_STOP;
                stall   = div_op_i;
                state_d = CTRL_IDLE;
            end

            default: begin
                state_d = CTRL_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= CTRL_IDLE;
            signed_q <= 1'b0;
            op1_q    <= '0;
            op2_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            whilo_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            signed_q <= signed_d;
            op1_q    <= op1_d;
            op2_q    <= op2_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            whilo_q  <= whilo_d;
        end
    end

    assign div_if.div_start_o  = start;
    assign div_if.div_annul_o  = flush_i;
    assign div_if.div_signed_o = sgn_out;
    assign div_if.div_op1_o    = op1_out;
    assign div_if.div_op2_o    = op2_out;

    assign stallreq_o  = stall;
    assign whilo_o     = whilo_q;
    assign hi_o        = hi_q;
    assign lo_o        = lo_q;
    assign busy_o      = (state_q != CTRL_IDLE);
    assign state_dbg_o = state_q;

endmodule

// File: doc/div_issue_ctrl.md
Name: div_issue_ctrl

Overview:
EX-stage initiator for the multicycle divider. It accepts DIV/DIVU instructions and drives the divider's start/annul/operand handshake. It holds the pipeline stalled until the divider reports ready, then returns remainder/quotient as a one-cycle HI/LO write. It sits between the EX datapath and the divider, and feeds the stall controller and the HI/LO write path.

Parameters:
DW, 32, operand width; the result is 2*DW.

Ports:
clk  in  1  clock
rst  in  1  reset: one clock, synchronous, active-high
div_op_i  in  1  current EX instruction is DIV/DIVU
signed_i  in  1  1 = DIV, 0 = DIVU
op1_i  in  DW  dividend
op2_i  in  DW  divisor
flush_i  in  1  pipeline flush/exception; abort any divide
div_ready_i  in  1  divider result ready
div_result_i  in  2*DW  {remainder, quotient} from divider
div_start_o  out  1  start request to divider
div_annul_o  out  1  abort request to divider
div_signed_o  out  1  signed select to divider
div_op1_o  out  DW  dividend to divider
div_op2_o  out  DW  divisor to divider
stallreq_o  out  1  stall request to pipeline control
whilo_o  out  1  one-cycle HI/LO write strobe
hi_o  out  DW  remainder
lo_o  out  DW  quotient
busy_o  out  1  state != IDLE

Behaviour:
- States: IDLE, BUSY, CLEAR. Reset: state IDLE; whilo_o=0; hi_o=lo_o=0; operand latches 0.
- div_annul_o = flush_i, in all states.
- IDLE:
  - Divider operand outputs pass op1_i/op2_i/signed_i through combinationally; the controller also latches them.
  - div_start_o = div_op_i & ~flush_i.
  - stallreq_o = div_start_o.
  - On div_op_i & ~flush_i, go to BUSY.
- BUSY:
  - Operand outputs come from the latches and are held stable. The divider re-reads sign bits at completion, so they must not change.
  - div_start_o = ~flush_i.
  - stallreq_o = ~div_ready_i & ~flush_i.
  - On div_ready_i & ~flush_i: register hi_o = div_result_i[2DW-1:DW], lo_o = div_result_i[DW-1:0]; whilo_o = 1 for exactly the next cycle; go to CLEAR. The pipeline advances on the ready cycle.
  - On flush_i: go to CLEAR; no write. Flush wins over a simultaneous ready.
- CLEAR:
  - div_start_o = 0 for one cycle, which returns the divider from its end state to free.
  - stallreq_o = div_op_i, so a back-to-back DIV waits one cycle.
  - Go to IDLE.
- Divide by zero: the divider returns 0/0 after its zero path. The controller treats this as a normal completion: hi=lo=0, whilo pulse.
- Latency: issue cycle to whilo_o = divider latency + 1. Stall cycles = cycles until ready.
- hi_o/lo_o hold their last written value between writes.
- Reset asserted mid-divide returns to IDLE. No write occurs.

Optional Feature:
DIV_ZERO_BYPASS_EN.
- Defined: in IDLE, a div_op_i with op2_i == 0 does not start the divider (div_start_o = 0, stallreq_o = 0). Next cycle it writes hi=lo=0 with a whilo_o pulse and stays in IDLE. Flush in the issue cycle suppresses the write.
- Undefined: a zero divisor goes through the divider like any other value.

Decomposition:
- Shared defines file: state encodings (CtrlIdle/CtrlBusy/CtrlClear), reusing DivStart/DivStop/DivResultReady and ZeroWord.
- No sub-module; a single FSM with operand/result registers.

Test Plan:
- Signed 7/2 (DIV: op1=7, op2=2) with a divider model ready after 35 cycles -> stallreq high for 35 cycles, then one whilo pulse with hi=1, lo=3; start drops in CLEAR.
- Signed 0xFFFFFFF9 / 2 (DIV) -> hi=0xFFFFFFFF, lo=0xFFFFFFFD. div_op1_o/div_signed_o stay constant while BUSY even though op1_i is randomized.
- DIVU 0xFFFFFFFF / 0x10 -> hi=0xF, lo=0x0FFFFFFF.
- flush_i at BUSY cycle 10, and separately on the same cycle as div_ready_i -> annul high, no whilo pulse, hi/lo unchanged, CLEAR then IDLE.
- Back-to-back DIVs (100/7, then 9/3) -> second start asserted only after one CLEAR cycle. Results are hi=2, lo=14, then hi=0, lo=3.
- Divisor 0 -> hi=lo=0 with whilo. With DIV_ZERO_BYPASS_EN: no div_start_o pulse, no stall, whilo one cycle after issue.
